// File: rtl/inv_sbox_layer_seq.sv
// inv_sbox_layer_seq: inverse Ascon 5-bit S-box layer over x0..x4, COLS_PER_CYCLE columns per clock.
// Define INV_SBOX_SELFCHECK_EN to build the forward-S-box round-trip checker behind err_o.
module inv_sbox_layer_seq #(
    parameter int COLS_PER_CYCLE = 8
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [319:0] state_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [319:0] state_o,
    output logic         busy_o,
    output logic         err_o
);
    localparam int C   = COLS_PER_CYCLE;
    localparam int NCH = (C > 0) ? 64 / C : 1;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    if (C != 1 && C != 2 && C != 4 && C != 8 &&
        C != 16 && C != 32 && C != 64) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1,2,4,8,16,32 or 64");
    end

    localparam logic [4:0] INV [32] = '{
        5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
        5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
        5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
        5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
    };

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_t;

    fsm_t            fsm_q, fsm_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [319:0]    state_q, state_d;
    logic [319:0]    proc_state;
    logic [5:0]      col;
    logic [4:0]      y;
    logic [4:0]      x;

`ifdef INV_SBOX_SELFCHECK_EN
    localparam logic [4:0] FWD [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };
    logic mism;
    logic chk_bad;
    logic err_q, err_d;
`endif

    // Bit index {lane, col}: lane 4 is x0 at [319:256] down to lane 0 is x4.
    always_comb begin
        proc_state = state_q;
        col        = '0;
        y          = '0;
        x          = '0;
`ifdef INV_SBOX_SELFCHECK_EN
        mism       = 1'b0;
`endif
        for (int i = 0; i < C; i++) begin
            col = 6'(int'(cnt_q) * C + i);
            y = {state_q[{3'd4, col}], state_q[{3'd3, col}],
                 state_q[{3'd2, col}], state_q[{3'd1, col}],
                 state_q[{3'd0, col}]};
            x = INV[y];
            proc_state[{3'd4, col}] = x[4];
            proc_state[{3'd3, col}] = x[3];
            proc_state[{3'd2, col}] = x[2];
            proc_state[{3'd1, col}] = x[1];
            proc_state[{3'd0, col}] = x[0];
`ifdef INV_SBOX_SELFCHECK_EN
            mism = mism | (FWD[x] != y);
`endif
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        unique case (fsm_q)
            IDLE: begin
                if (valid_i) begin
                    state_d = state_i;
                    cnt_d   = '0;
                    fsm_d   = BUSY;
                end
            end
            BUSY: begin
                state_d = proc_state;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(NCH - 1)) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q   <= IDLE;
            cnt_q   <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

`ifdef INV_SBOX_SELFCHECK_EN
    assign chk_bad = mism & (fsm_q == BUSY);
    assign err_d   = err_q | chk_bad;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign ready_o = (fsm_q == IDLE);
    assign valid_o = (fsm_q == DONE);
    assign busy_o  = (fsm_q == BUSY);
    assign state_o = state_q;

endmodule
